// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_t, INSTR_NOP, PC_STEP, align_pc().
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_OUT = 2'd2,
    DISCARD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch block's memory, decode and redirect signals.
// Latency: n/a (wires only).
// Backpressure: stall from decode; imem_ack from memory.
// Ports: master = fetch controller side, slave = memory/decode/branch side.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a word fetched while the output is blocked.
// Latency: load visible on the next cycle.
// Backpressure: none of its own; flush beats load beats unload.
// Ports: clk, rst, load/unload/flush controls, load_pc/load_instr data, valid/pc/instr state.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 32'd0;
      instr <= INSTR_NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch: one outstanding memory request, registered output word, redirect handling.
// Latency: ack in cycle N -> if_valid in cycle N+1; first request two cycles after reset release.
// Backpressure: stall holds the output; a word arriving into a full output waits in the skid buffer.
// Ports: clk, rst (async, active high), bus (fetch_if.master: imem_*, stall, redirect_*, if_*).
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pending_pc;
  logic         if_valid_q;
  logic [31:0]  if_pc_q, if_instr_q;

  logic         skid_valid;
  logic [31:0]  skid_pc, skid_instr;

  logic         xfer, out_loadable;
  logic [31:0]  redir_tgt;

  // control decoded by the output process
  logic load_out, load_skid, unload_skid, flush;
  logic pc_sel_redirect, pc_sel_pending, pc_inc, capture_pending;

  assign bus.imem_req  = (state_q == FETCH) || (state_q == DISCARD);
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

  assign xfer         = bus.imem_req && bus.imem_ack;
  assign out_loadable = !if_valid_q || !bus.stall;
  assign redir_tgt    = align_pc(bus.redirect_pc);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = FETCH;
      FETCH: begin
        if (bus.redirect_valid)      state_d = xfer ? FETCH : DISCARD;
        else if (xfer && !out_loadable) state_d = WAIT_OUT;
      end
      WAIT_OUT: if (bus.redirect_valid || !bus.stall) state_d = FETCH;
      DISCARD:  if (xfer) state_d = FETCH;
      default:  state_d = IDLE;
    endcase
  end

  // outputs / datapath controls
  always_comb begin
    load_out        = 1'b0;
    load_skid       = 1'b0;
    unload_skid     = 1'b0;
    flush           = bus.redirect_valid;
    pc_sel_redirect = 1'b0;
    pc_sel_pending  = 1'b0;
    pc_inc          = 1'b0;
    capture_pending = 1'b0;
    case (state_q)
      IDLE: pc_sel_redirect = bus.redirect_valid;
      FETCH: begin
        if (bus.redirect_valid) begin
          // the in-flight word is stale; if it has not returned yet,
          // remember the target and drain it in DISCARD
          if (xfer) pc_sel_redirect = 1'b1;
          else      capture_pending = 1'b1;
        end else if (xfer) begin
          pc_inc = 1'b1;
          if (out_loadable) load_out  = 1'b1;
          else              load_skid = 1'b1;
        end
      end
      WAIT_OUT: begin
        if (bus.redirect_valid) pc_sel_redirect = 1'b1;
        else if (!bus.stall)    unload_skid     = 1'b1;
      end
      DISCARD: begin
        if (xfer) begin
          pc_sel_redirect = bus.redirect_valid;
          pc_sel_pending  = !bus.redirect_valid;
        end else begin
          capture_pending = bus.redirect_valid;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pending_pc <= 32'd0;
    end else begin
      if (pc_sel_redirect)     pc_q <= redir_tgt;
      else if (pc_sel_pending) pc_q <= pending_pc;
      else if (pc_inc)         pc_q <= pc_q + PC_STEP;
      if (capture_pending) pending_pc <= redir_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= INSTR_NOP;
    end else if (flush) begin
      if_valid_q <= 1'b0;
      if_instr_q <= INSTR_NOP;
    end else if (load_out) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= pc_q;
      if_instr_q <= bus.imem_rdata;
    end else if (unload_skid) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= skid_pc;
      if_instr_q <= skid_instr;
    end else if (if_valid_q && !bus.stall) begin
      if_valid_q <= 1'b0;
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (load_skid),
    .unload     (unload_skid),
    .flush      (flush),
    .load_pc    (pc_q),
    .load_instr (bus.imem_rdata),
    .valid      (skid_valid),
    .pc         (skid_pc),
    .instr      (skid_instr)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller against a transaction-level reference model.
// Latency: n/a.
// Backpressure: stall, ack latency and redirects are randomized.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus2 ();

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk), .rst (rst), .bus (bus.master)
  );
  fetch_controller #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the stream of accepted words still owed to decode,
  // the address the next/current request must carry, and whether the
  // current request's data is to be thrown away.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  word_t       q[$];
  logic [31:0] m_addr, m_target;
  bit          m_idle, m_drop, m_nop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset(input logic [31:0] rpc);
    q.delete();
    m_addr   = rpc;
    m_target = 32'd0;
    m_idle   = 1'b1;
    m_drop   = 1'b0;
    m_nop    = 1'b1;
  endtask

  task automatic model_step(input bit st, input bit rv, input logic [31:0] rpc, input bit ack);
    bit exp_req = !m_idle && (q.size() < 2);
    bit xfer    = exp_req && ack;
    logic [31:0] tgt = {rpc[31:2], 2'b00};
    word_t w;
    if (rv) begin
      q.delete();
      m_nop = 1'b1;
      if (m_idle) begin
        m_addr = tgt;
        m_idle = 1'b0;
      end else if (m_drop) begin
        if (xfer) begin m_addr = tgt; m_drop = 1'b0; end
        else m_target = tgt;
      end else if (exp_req) begin
        if (xfer) m_addr = tgt;
        else begin m_drop = 1'b1; m_target = tgt; end
      end else begin
        m_addr = tgt;
      end
    end else begin
      m_idle = 1'b0;
      if (q.size() != 0 && !st) void'(q.pop_front());
      if (xfer) begin
        if (m_drop) begin
          m_addr = m_target;
          m_drop = 1'b0;
        end else begin
          w.pc = m_addr;
          w.instr = mem_word(m_addr);
          q.push_back(w);
          m_addr = m_addr + 32'd4;
          m_nop = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit exp_req = !m_idle && (q.size() < 2);
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_addr);
    chk("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("if_pc", bus.if_pc, q[0].pc);
      chk("if_instr", bus.if_instr, q[0].instr);
    end else if (m_nop) begin
      chk("if_instr_nop", bus.if_instr, INSTR_NOP);
    end
  endtask

  // One clock: check state seen since the last edge, drive this cycle's
  // inputs, advance the model, then move to the next falling edge.
  task automatic cycle(input bit st, input bit rv, input logic [31:0] rpc, input bit ack);
    check_outputs();
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_ack       = ack;
    bus.imem_rdata     = ack ? mem_word(bus.imem_addr) : $urandom;
    model_step(st, rv, rpc, ack);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_instr", bus.if_instr, INSTR_NOP);
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset(32'h0000_0000);
  endtask

  logic [31:0] e2 [4];

  initial begin
    int p_ack, p_stall, p_redir;
    logic [31:0] rpc;
    rst = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.stall = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0000_0013; bus2.stall = 1'b0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'd0;
    e2[0] = 32'd0; e2[1] = 32'hFFFF_FFF8; e2[2] = 32'hFFFF_FFFC; e2[3] = 32'h0000_0000;
    #2;
    do_reset();

    // zero-wait streaming; second instance checks PC wrap from FFFF_FFF8
    for (int i = 0; i < 6; i++) begin
      if (i == 0) chk("wrap_idle_req", 32'(bus2.imem_req), 32'd0);
      else if (i < 4) chk("wrap_addr", bus2.imem_addr, e2[i]);
      if (i >= 1) chk("zw_addr", bus.imem_addr, 32'((i - 1) * 4));
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
    end

    // word arrives while output is blocked -> skid, no request
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("wait_out_req", 32'(bus.imem_req), 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);

    // redirect while ack is 3 cycles away
    cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("redir_target", bus.imem_addr, 32'h0000_0100);

    // redirect coincident with ack and stall
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("redir_ack_valid", 32'(bus.if_valid), 32'd0);
    chk("redir_ack_addr", bus.imem_addr, 32'h0000_0200);

    // random traffic in phases of varying memory latency and pressure
    for (int seg = 0; seg < 6; seg++) begin
      p_ack   = (seg % 3 == 0) ? 100 : (seg % 3 == 1) ? 50 : 20;
      p_stall = (seg < 3) ? 25 : 60;
      p_redir = (seg % 2 == 0) ? 5 : 12;
      for (int c = 0; c < 500; c++) begin
        rpc = $urandom;
        if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        if ($urandom_range(599) == 0) do_reset();
        else cycle($urandom_range(99) < p_stall, $urandom_range(99) < p_redir,
                   rpc, $urandom_range(99) < p_ack);
      end
    end

    // reset with a request outstanding
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b0);
    chk("pre_rst_req", 32'(bus.imem_req), 32'd1);
    do_reset();

    // reset while parked in WAIT_OUT
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("pre_rst_wait_req", 32'(bus.imem_req), 32'd0);
    chk("pre_rst_wait_valid", 32'(bus.if_valid), 32'd1);
    do_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("restart_addr", bus.imem_addr, 32'h0000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory request.
REQ-005 imem_addr  output  32  request address; equals pc_q while imem_req=1.
REQ-006 imem_ack  input  1  transfer completes in a cycle where imem_req=1 and imem_ack=1.
REQ-007 imem_rdata  input  32  instruction word, valid in the ack cycle only.
REQ-008 stall  input  1  decode stage refuses the current if_* word.
REQ-009 redirect_valid  input  1  branch/jump redirect request.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 if_valid  output  1  registered output word valid.
REQ-012 if_pc  output  32  PC of the output word.
REQ-013 if_instr  output  32  output instruction word.

Function
REQ-014 The output register is consumed in a cycle where if_valid=1 and stall=0; it can load when if_valid=0 or stall=0.
REQ-015 There is at most one outstanding request; once imem_req rises, imem_addr stays stable until ack.
REQ-016 States are IDLE, FETCH, WAIT_OUT and DISCARD.
REQ-017 IDLE: imem_req=0; go to FETCH on the next cycle.
REQ-018 FETCH: imem_req=1.
- On ack with a loadable output: load if_valid=1, if_pc=pc_q, if_instr=imem_rdata; pc_q+=4; stay in FETCH.
- On ack with a full output and stall=1: load the skid buffer; pc_q+=4; go to WAIT_OUT.
REQ-019 WAIT_OUT: imem_req=0; when stall=0, the skid word moves to the output register (if_valid stays 1); go to FETCH.
REQ-020 Redirect has priority over stall and ack.
- It clears if_valid and the skid buffer, and sets if_instr to INSTR_NOP on the next edge.
REQ-021 Redirect in FETCH:
- With ack in the same cycle: drop rdata; pc_q<=redirect_pc; stay in FETCH.
- Without ack: store the target in pending_pc; go to DISCARD.
REQ-022 Redirect in IDLE or WAIT_OUT: pc_q<=redirect_pc; go to FETCH.
REQ-023 DISCARD: imem_req=1 with the old pc_q; if_valid=0.
- A new redirect overwrites pending_pc.
- On ack: drop rdata; pc_q<=pending_pc (or redirect_pc if a redirect arrives the same cycle); go to FETCH.
REQ-024 redirect_pc[1:0] is forced to 2'b00 on capture.
REQ-025 PC increment is modulo 2^32: 32'hFFFF_FFFC+4 gives 32'h0000_0000.
REQ-026 Fetch latency: ack in cycle N gives if_valid=1 in cycle N+1.
REQ-027 if_* registers hold their value while if_valid=1 and stall=1.

Reset
REQ-028 On rst=1, immediately and independent of clk:
- state=IDLE, pc_q=RESET_PC, pending_pc=0, skid empty.
- imem_req=0, if_valid=0, if_pc=0, if_instr=INSTR_NOP.
REQ-029 A reset during an outstanding request abandons it; the memory model must tolerate a dropped request.
REQ-030 The first request is issued in the second cycle after rst deasserts (via IDLE).

Structure
REQ-031 Shared package fetch_pkg holds the fetch_state_t enum, INSTR_NOP (32'h0000_0013) and PC_STEP (4).
REQ-032 A one-entry skid buffer is the natural sub-module, fetch_skid_buffer (load, unload, flush, valid, pc, instr).
REQ-033 All outputs are registered, except imem_req and imem_addr, which decode from state and pc_q.

Verification
REQ-034 Reset release, zero-wait memory, stall=0 -> imem_addr 0,4,8,… one per cycle; if_pc lags by one cycle; if_valid=1 from the third cycle.
REQ-035 Raise stall with a request in flight, ack arrives -> state WAIT_OUT, imem_req=0, if_pc held; stall drops -> skid word (next PC) appears next cycle.
REQ-036 Redirect to 32'h0000_0103 while an ack is pending 3 cycles -> imem_addr stays the old PC until ack, if_valid=0 throughout, next request to 32'h0000_0100.
REQ-037 Redirect coincident with ack and stall=1 -> rdata dropped, if_valid=0 next cycle, next imem_addr = redirect target.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Assert rst mid-request and mid-WAIT_OUT -> all outputs take reset values asynchronously; fetch restarts at RESET_PC.
